// File: rtl/btn_evt_pkg.sv
// Shared event encoding and default sizing for the button event arbiter.
package btn_evt_pkg;

    typedef enum logic {
        EVT_RISE = 1'b0,
        EVT_FALL = 1'b1
    } evt_kind_e;

    localparam int unsigned N_BTN_DEFAULT           = 4;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 250000;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, stability counter and debounced level.
module btn_debounce
    import btn_evt_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // The counter stops at CNT_LAST because the level flips there, so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= ~level;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/button_event_arbiter.sv
// Debounced buttons -> edge events, pending slots, round-robin arbitration onto a
// valid/ready output. Define BTN_FALL_EVT_EN to also report release (falling) events.
module button_event_arbiter
    import btn_evt_pkg::*;
#(
    parameter int unsigned N_BTN           = N_BTN_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_BTN-1:0]         btn_in,
    output logic [N_BTN-1:0]         btn_level,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [$clog2(N_BTN)-1:0] evt_id,
    output logic                     evt_kind,
    output logic                     overflow
);

    localparam int unsigned IW = $clog2(N_BTN);
    localparam int unsigned SW = IW + 1;
    localparam int unsigned NS = 2 * N_BTN;

    logic [N_BTN-1:0] level_prev;
    logic [NS-1:0]    pending;
    logic [NS-1:0]    edge_set;
    logic [NS-1:0]    slot_mask;
    logic [NS-1:0]    clr;
    logic [SW-1:0]    ptr;
    logic [SW-1:0]    gnt;
    logic [SW-1:0]    ptr_next;
    logic             found;
    logic             load;

    for (genvar i = 0; i < N_BTN; i++) begin : g_db
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (btn_in[i]),
            .level (btn_level[i])
        );
    end

    // Slot 2*ch is the press, slot 2*ch+1 the release of channel ch.
    always_comb begin
        edge_set  = '0;
        slot_mask = '0;
        for (int unsigned ch = 0; ch < N_BTN; ch++) begin
            edge_set[2*ch]  = btn_level[ch] & ~level_prev[ch];
            slot_mask[2*ch] = 1'b1;
`ifdef BTN_FALL_EVT_EN
            edge_set[2*ch+1]  = ~btn_level[ch] & level_prev[ch];
            slot_mask[2*ch+1] = 1'b1;
`endif
        end
    end

    always_comb begin
        int unsigned s;
        found = 1'b0;
        gnt   = '0;
        s     = 0;
        for (int unsigned k = 0; k < NS; k++) begin
            s = (32'(ptr) + k) % NS;
            if (!found && pending[s] && slot_mask[s]) begin
                found = 1'b1;
                gnt   = SW'(s);
            end
        end
    end

    assign load     = ~evt_valid | evt_ready;
    assign clr      = (load && found) ? (NS'(1) << gnt) : '0;
    assign ptr_next = (gnt == SW'(NS - 1)) ? '0 : gnt + 1'b1;

    // A fresh edge re-sets a slot even if the grant clears it in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_prev <= '0;
            pending    <= '0;
            overflow   <= 1'b0;
            evt_valid  <= 1'b0;
            evt_id     <= '0;
            ptr        <= '0;
        end else begin
            level_prev <= btn_level;
            pending    <= (pending & ~clr) | edge_set;
            overflow   <= |(edge_set & pending & ~clr);
            if (load) begin
                evt_valid <= found;
                if (found) begin
                    evt_id <= gnt[SW-1:1];
                    ptr    <= ptr_next;
                end
            end
        end
    end

`ifdef BTN_FALL_EVT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_kind <= 1'b0;
        end else if (load && found) begin
            evt_kind <= gnt[0];
        end
    end
`else
    assign evt_kind = EVT_RISE;
`endif

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter with N_BTN=4, DEBOUNCE_CYCLES=4.
module tb_button_event_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn_in;
    logic [3:0] btn_level;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_id;
    logic       evt_kind;
    logic       overflow;

    int checks;
    int errors;
    int ovf_cnt;

    button_event_arbiter #(
        .N_BTN           (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_kind  (evt_kind),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (overflow === 1'b1) ovf_cnt++;
        end
    endtask

    task automatic check_evt(input string tag, input logic [1:0] id, input logic kind);
        check({tag, "_valid"}, 32'(evt_valid), 32'd1);
        check({tag, "_id"},    32'(evt_id),    32'(id));
        check({tag, "_kind"},  32'(evt_kind),  32'(kind));
    endtask

    task automatic do_reset();
        btn_in = '0;
        rst_n  = 1'b0;
        tick(2);
        rst_n  = 1'b1;
        tick(1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        ovf_cnt   = 0;
        rst_n     = 1'b0;
        btn_in    = '0;
        evt_ready = 1'b0;
        #1;
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_id",    32'(evt_id),    32'd0);
        check("rst_kind",  32'(evt_kind),  32'd0);
        check("rst_ovf",   32'(overflow),  32'd0);
        check("rst_level", 32'(btn_level), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // Single press, latency of 8 edges
        evt_ready = 1'b1;
        btn_in    = 4'b0100;
        tick(7);
        check("t1_early", 32'(evt_valid), 32'd0);
        tick(1);
        check_evt("t1_evt", 2'd2, 1'b0);
        check("t1_level", 32'(btn_level), 32'h4);
        tick(1);
        check("t1_one_cycle", 32'(evt_valid), 32'd0);

        // 3-cycle glitch on channel 1 must be rejected
        btn_in = 4'b0110;
        tick(3);
        btn_in = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("t2_level", 32'(btn_level), 32'h4);
            check("t2_valid", 32'(evt_valid), 32'd0);
        end

        // Simultaneous press on 0 and 3 with backpressure
        do_reset();
        evt_ready = 1'b0;
        btn_in    = 4'b1001;
        tick(8);
        check_evt("t3_first", 2'd0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("t3_hold_valid", 32'(evt_valid), 32'd1);
            check("t3_hold_id",    32'(evt_id),    32'd0);
        end
        evt_ready = 1'b1;
        tick(1);
        check_evt("t3_second", 2'd3, 1'b0);
        tick(1);
        check("t3_drain", 32'(evt_valid), 32'd0);

        // Press/release bursts on channel 1 while the consumer stalls
        do_reset();
        evt_ready = 1'b0;
        ovf_cnt   = 0;
        btn_in    = 4'b0010;
        tick(8);
        check_evt("t4_first", 2'd1, 1'b0);
        btn_in = 4'b0000;
        tick(8);
        btn_in = 4'b0010;
        tick(8);
        btn_in = 4'b0000;
        tick(8);
        btn_in = 4'b0010;
        tick(8);
        check_evt("t4_held", 2'd1, 1'b0);
        check("t4_level", 32'(btn_level), 32'h2);
`ifdef BTN_FALL_EVT_EN
        check("t4_ovf_pulses", 32'(ovf_cnt), 32'd2);
        evt_ready = 1'b1;
        tick(1);
        check_evt("t4_fall", 2'd1, 1'b1);
        tick(1);
        check_evt("t4_rise", 2'd1, 1'b0);
`else
        check("t4_ovf_pulses", 32'(ovf_cnt), 32'd1);
        evt_ready = 1'b1;
        tick(1);
        check_evt("t4_rise", 2'd1, 1'b0);
`endif
        tick(1);
        check("t4_drain", 32'(evt_valid), 32'd0);

        // Reset in the middle of a stalled handshake
        evt_ready = 1'b0;
        btn_in    = 4'b0011;
        tick(8);
        check_evt("t5_pre", 2'd0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_async_valid", 32'(evt_valid), 32'd0);
        check("t5_async_id",    32'(evt_id),    32'd0);
        check("t5_async_kind",  32'(evt_kind),  32'd0);
        check("t5_async_ovf",   32'(overflow),  32'd0);
        check("t5_async_level", 32'(btn_level), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(7);
        check("t5_early", 32'(evt_valid), 32'd0);
        tick(1);
        check_evt("t5_post0", 2'd0, 1'b0);
        evt_ready = 1'b1;
        tick(1);
        check_evt("t5_post1", 2'd1, 1'b0);
        tick(1);
        check("t5_drain", 32'(evt_valid), 32'd0);
        check("t5_level", 32'(btn_level), 32'h3);

        // Press then release on channel 3
        do_reset();
        evt_ready = 1'b1;
        btn_in    = 4'b1000;
        tick(8);
        check_evt("t6_press", 2'd3, 1'b0);
        tick(1);
        check("t6_gap", 32'(evt_valid), 32'd0);
        btn_in = 4'b0000;
        tick(7);
        check("t6_early", 32'(evt_valid), 32'd0);
        tick(1);
`ifdef BTN_FALL_EVT_EN
        check_evt("t6_release", 2'd3, 1'b1);
`else
        check("t6_no_release", 32'(evt_valid), 32'd0);
`endif
        tick(1);
        check("t6_drain", 32'(evt_valid), 32'd0);
        check("t6_level", 32'(btn_level), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
